uart_word_assembler: RTL and testbench
======================================

Name: uart_word_assembler

Overview:
- Sits directly downstream of the UART receiver.
- Consumes one received byte per `rx_done` pulse and packs BYTES_PER_WORD consecutive bytes, little-endian, into one wide word for the correlator control/config path.
- Presents each word on a valid/ready interface.
- Detects inter-byte timeouts (partial-word discard) and output overflow.

Parameters:
- BYTE_W, 8: width of each received byte.
- BYTES_PER_WORD, 4: bytes per assembled word; legal range 1 to 16.
- TIMEOUT_CYCLES, 20000: maximum clk cycles allowed between bytes of one word.
- SYNC_BYTE, 8'hA5: header value, used only when ASSEMBLER_SYNC_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  BYTE_W  received byte; valid in the cycle rx_done=1.
- rx_done  in  1  single-cycle strobe, one per received byte.
- out_data  out  BYTE_W*BYTES_PER_WORD  assembled word; byte 0 in bits [BYTE_W-1:0].
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- overflow  out  1  sticky: a completed word was dropped.
- timeout_err  out  1  sticky: a partial word was discarded on timeout.
- err_clr  in  1  synchronous clear of both sticky flags.
- word_cnt  out  16  count of words accepted into the output register; wraps at 2^16.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, byte index 0, timeout counter 0, assembly register 0, out_data 0, out_valid 0, overflow 0, timeout_err 0, word_cnt 0.
- State machine:
  - IDLE: an rx_done writes rx_data into byte slot 0, sets byte index to 1, and moves to COLLECT. If BYTES_PER_WORD==1 the word completes immediately and the state stays IDLE.
  - COLLECT: each rx_done writes slot[idx] and increments idx.
  - When the slot BYTES_PER_WORD-1 is written, the word is complete: idx returns to 0 and the state returns to IDLE.
- Completion handoff: the complete word (assembly register plus the byte arriving this cycle) is loaded into out_data in the next cycle, and out_valid rises in that same cycle. Latency from the final rx_done to out_valid is 1 cycle.
- Output handshake:
  - out_valid stays high and out_data stays stable until out_valid && out_ready.
  - out_valid drops in the cycle after the handshake unless a new word loads in that cycle.
- Simultaneous complete and handshake: if a word completes in the same cycle the held word is consumed, the new word loads and out_valid stays 1. There is no overflow in this case.
- Overflow: if a word completes while out_valid=1 and out_ready=0, the new word is dropped, overflow is set, and out_data is unchanged.
- Timeout:
  - The counter runs only in COLLECT and is zeroed on every rx_done.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done, the partial word is discarded, idx is set to 0, the state returns to IDLE, and timeout_err is set.
  - rx_done in the expiry cycle wins: the byte is taken and no timeout occurs.
- err_clr: clears overflow and timeout_err. If an error event occurs in the same cycle, the event wins and the flag stays 1.
- word_cnt: increments on each load into out_data, not on dropped words.
- Counter width: the timeout counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates; it does not wrap.

Optional Feature:
- Macro: ASSEMBLER_SYNC_EN.
- Defined:
  - An extra state, HUNT, is the reset and post-word state.
  - In HUNT, bytes not equal to SYNC_BYTE are ignored. SYNC_BYTE moves to IDLE, and the following bytes form the word.
  - Timeout applies from the sync byte onward; on timeout the state returns to HUNT.
  - After word completion the state returns to HUNT.
- Undefined: no HUNT state; behaviour is exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef (HUNT, IDLE, COLLECT);
  - default SYNC_BYTE constant;
  - byte width constant shared with the UART receiver.
- One natural sub-module, uart_timeout_cnt: a saturating counter with clear, enable and expiry output.
- Packing and handshake stay in the top module.

Test Plan:
- Four rx_done pulses carrying 11,22,33,44, out_ready=1 -> out_data=32'h44332211, out_valid high for exactly 1 cycle, 1 cycle after the 4th strobe; word_cnt=1.
- Two bytes, then idle TIMEOUT_CYCLES cycles, then four bytes AA,BB,CC,DD -> timeout_err=1; out_data=32'hDDCCBBAA; no stale bytes appear in the word.
- out_ready=0, send two full words -> first word held stable; overflow=1; word_cnt=1. Then err_clr -> overflow=0.
- Word completes in the same cycle out_ready consumes the prior word -> out_valid stays 1; out_data updates to the new word; overflow stays 0.
- Assert rst_n low mid-word (after 2 bytes), release, send 4 bytes -> out_data equals exactly those 4 bytes.
- With ASSEMBLER_SYNC_EN defined: send 00,A5,01,02,03,04 -> out_data=32'h04030201. Then 05 with no preceding A5 is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: byte width, default
// header byte and the word assembler state encoding.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [UART_BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // HUNT is only reachable when the assembler is built with header sync.
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_COLLECT = 2'd2
    } asm_state_t;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Saturating inter-byte timeout counter. Counts while enabled, is zeroed
// by clear, and flags expiry while enabled at TIMEOUT_CYCLES-1.
module uart_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count up while enabled, hold at the expiry value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/uart_word_assembler.sv
// Packs consecutive UART bytes little-endian into wide words and presents
// them on a valid/ready interface, with inter-byte timeout and overflow
// detection. Optional header synchronisation is built with the
// ASSEMBLER_SYNC_EN macro: bytes are ignored until SYNC_BYTE arrives.
module uart_word_assembler
    import uart_pkg::*;
#(
    parameter int                BYTE_W         = UART_BYTE_W,
    parameter int                BYTES_PER_WORD = 4,
    parameter int                TIMEOUT_CYCLES = 20000,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = BYTE_W'(SYNC_BYTE_DEFAULT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [BYTE_W-1:0]                rx_data,
    input  logic                             rx_done,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overflow,
    output logic                             timeout_err,
    input  logic                             err_clr,
    output logic [15:0]                      word_cnt
);

    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

`ifdef ASSEMBLER_SYNC_EN
    localparam asm_state_t ST_REST = ST_HUNT;
`else
    localparam asm_state_t ST_REST = ST_IDLE;
`endif

    asm_state_t        r_state;
    asm_state_t        w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_asm;
    logic [WORD_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_overflow;
    logic              r_timeout_err;
    logic [15:0]       r_word_cnt;

    logic              w_take;
    logic              w_complete;
    logic              w_timeout;
    logic              w_expired;
    logic              w_cnt_en;
    logic              w_cnt_clr;
    logic              w_load;
    logic              w_drop;
    logic [WORD_W-1:0] w_word;

    // Decode byte acceptance, completion, timeout and counter control.
    always_comb begin
        w_take     = rx_done && ((r_state == ST_IDLE) || (r_state == ST_COLLECT));
        w_complete = w_take && (r_idx == LAST_IDX);
`ifdef ASSEMBLER_SYNC_EN
        // After the header byte the word is already under way, so the
        // timeout also guards the wait for its first data byte.
        w_cnt_en   = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
`else
        w_cnt_en   = (r_state == ST_COLLECT);
`endif
        w_cnt_clr  = rx_done || !w_cnt_en;
        w_timeout  = w_expired && !rx_done;
        w_load     = w_complete && (!r_out_valid || out_ready);
        w_drop     = w_complete && r_out_valid && !out_ready;
    end

    // Word as it stands including the byte arriving this cycle.
    always_comb begin
        w_word = r_asm;
        w_word[int'(r_idx)*BYTE_W +: BYTE_W] = rx_data;
    end

    uart_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    // Next-state logic for the assembly state machine.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HUNT: begin
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE, ST_COLLECT: begin
                if (w_take) begin
                    w_next_state = w_complete ? ST_REST : ST_COLLECT;
                end else if (w_timeout) begin
                    w_next_state = ST_REST;
                end
            end
            default: w_next_state = ST_REST;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_REST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Byte slot index and assembly register; both restart on completion or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (w_complete || w_timeout) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (w_take) begin
            r_idx <= r_idx + IDX_W'(1);
            r_asm <= w_word;
        end
    end

    // Output register and handshake; a completed word loads if the slot is free or being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_word_cnt  <= '0;
        end else if (w_load) begin
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
            r_word_cnt  <= r_word_cnt + 16'd1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;
    assign word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed testbench for uart_word_assembler (4 bytes/word, short timeout).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_word_assembler;

    localparam int TC = 40;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        timeout_err;
    logic        err_clr;
    logic [15:0] word_cnt;

    int n_checks = 0;
    int n_errors = 0;

    uart_word_assembler #(
        .BYTE_W         (8),
        .BYTES_PER_WORD (4),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .word_cnt    (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_sync();
`ifdef ASSEMBLER_SYNC_EN
        send_byte(8'hA5);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        idle(2);
        chk("rst_valid",    out_valid,   1'b0);
        chk("rst_data",     out_data,    32'h0);
        chk("rst_ovf",      overflow,    1'b0);
        chk("rst_tmo",      timeout_err, 1'b0);
        chk("rst_cnt",      word_cnt,    16'd0);
        rst_n = 1'b1;
        idle(1);

        // Basic word, consumer always ready
        out_ready = 1'b1;
        send_sync();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("t1_no_early_valid", out_valid, 1'b0);
        send_byte(8'h44);
        chk("t1_valid",     out_valid, 1'b1);
        chk("t1_data",      out_data,  32'h44332211);
        chk("t1_cnt",       word_cnt,  16'd1);
        idle(1);
        chk("t1_valid_drop", out_valid, 1'b0);

        // Partial word abandoned on timeout, then a clean word
        send_sync();
        send_byte(8'h55);
        send_byte(8'h66);
        idle(TC - 1);
        chk("t2_tmo_not_yet", timeout_err, 1'b0);
        idle(1);
        chk("t2_tmo_set",   timeout_err, 1'b1);
        chk("t2_no_word",   out_valid,   1'b0);
        send_sync();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        chk("t2_data",      out_data,  32'hDDCCBBAA);
        chk("t2_cnt",       word_cnt,  16'd2);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t2_tmo_clr",   timeout_err, 1'b0);

        // Byte arriving exactly in the expiry cycle is kept
        send_sync();
        send_byte(8'h01);
        idle(TC - 1);
        send_byte(8'h02);
        idle(TC - 1);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("t3_no_tmo",    timeout_err, 1'b0);
        chk("t3_data",      out_data,    32'h04030201);
        chk("t3_cnt",       word_cnt,    16'd3);
        idle(1);

        // Overflow while the consumer stalls
        out_ready = 1'b0;
        send_sync();
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        send_byte(8'h40);
        chk("t4_first",     out_data,  32'h40302010);
        idle(3);
        chk("t4_hold_valid", out_valid, 1'b1);
        chk("t4_hold_data",  out_data,  32'h40302010);
        send_sync();
        send_byte(8'h50);
        send_byte(8'h60);
        send_byte(8'h70);
        send_byte(8'h80);
        chk("t4_ovf",       overflow,  1'b1);
        chk("t4_kept_data", out_data,  32'h40302010);
        chk("t4_cnt",       word_cnt,  16'd4);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t4_ovf_clr",   overflow,  1'b0);

        // Drop coinciding with err_clr: the event keeps the flag set
        send_sync();
        send_byte(8'h91);
        send_byte(8'h92);
        send_byte(8'h93);
        err_clr = 1'b1;
        send_byte(8'h94);
        err_clr = 1'b0;
        chk("t4_ovf_wins",  overflow,  1'b1);
        chk("t4_cnt_drop",  word_cnt,  16'd4);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t4_ovf_clr2",  overflow,  1'b0);

        // Completion in the same cycle as the handshake of the held word
        send_sync();
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        out_ready = 1'b1;
        send_byte(8'h0D);
        chk("t5_valid",     out_valid, 1'b1);
        chk("t5_data",      out_data,  32'h0D0C0B0A);
        chk("t5_no_ovf",    overflow,  1'b0);
        chk("t5_cnt",       word_cnt,  16'd5);
        idle(1);
        chk("t5_drain",     out_valid, 1'b0);

        // Reset in the middle of a word
        send_sync();
        send_byte(8'hE1);
        send_byte(8'hE2);
        rst_n = 1'b0;
        idle(1);
        chk("t6_rst_cnt",   word_cnt,  16'd0);
        chk("t6_rst_data",  out_data,  32'h0);
        rst_n = 1'b1;
        idle(1);
        send_sync();
        send_byte(8'h9A);
        send_byte(8'hBC);
        send_byte(8'hDE);
        send_byte(8'hF0);
        chk("t6_data",      out_data,  32'hF0DEBC9A);
        chk("t6_cnt",       word_cnt,  16'd1);
        idle(1);

`ifdef ASSEMBLER_SYNC_EN
        // Header hunting: leading junk skipped, unsynchronised bytes ignored
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("s1_data",      out_data,  32'h04030201);
        chk("s1_cnt",       word_cnt,  16'd2);
        idle(1);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        idle(1);
        chk("s1_ignored_valid", out_valid, 1'b0);
        chk("s1_ignored_cnt",   word_cnt,  16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
